// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Parametrised pipeline stage register with a valid/ready handshake and a
//   2-entry skid buffer. ready_o depends on state only, so there is no
//   combinational path from ready_i to ready_o. Supports a synchronous flush
//   (drop everything held and any transfer this cycle) and a per-transfer kill
//   (store the entry as a NOP by zeroing its control field).
//
// Ports
//   clk_i    clock, all state updates on the rising edge
//   rst_i    synchronous reset, active-high
//   valid_i  upstream entry valid
//   ready_o  stage can accept (decoded from state)
//   ctrl_i   upstream control field (CTRL_W)
//   data_i   upstream payload field (DATA_W)
//   kill_i   capture the current transfer with ctrl = 0
//   flush_i  discard held entries and any transfer this cycle
//   valid_o  downstream entry valid
//   ready_i  downstream accepts
//   ctrl_o   held control field
//   data_o   held payload field
//   full_o   skid entry occupied
module pipe_stage_skid #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 111
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              kill_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o
);

    if (CTRL_W < 1 || DATA_W < 1) begin : g_bad_param
        $error("pipe_stage_skid: CTRL_W and DATA_W must be >= 1");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl, cap_ctrl;
    logic [DATA_W-1:0] m_data, s_data;
    logic              acc, dq;
    logic              ld_m_in, ld_s_in, ld_m_s;

    assign valid_o = (state != EMPTY);
    assign ready_o = (state != TWO);
    assign full_o  = (state == TWO);
    assign ctrl_o  = m_ctrl;
    assign data_o  = m_data;

    assign acc      = valid_i & ready_o;
    assign dq       = valid_o & ready_i;
    assign cap_ctrl = kill_i ? '0 : ctrl_i;

    always_comb begin
        state_nxt = state;
        ld_m_in   = 1'b0;
        ld_s_in   = 1'b0;
        ld_m_s    = 1'b0;
        case (state)
            EMPTY: begin
                if (acc) begin
                    ld_m_in   = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (acc && dq) begin
                    ld_m_in = 1'b1;
                end else if (acc) begin
                    // M is still being presented: park the younger entry in S
                    ld_s_in   = 1'b1;
                    state_nxt = TWO;
                end else if (dq) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                // ready_o is low here, so no upstream transfer can occur
                if (dq) begin
                    ld_m_s    = 1'b1;
                    state_nxt = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush wins over any load; a same-cycle dq still completes downstream
        if (flush_i) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= EMPTY;
            m_ctrl <= '0;
            m_data <= '0;
            s_ctrl <= '0;
            s_data <= '0;
        end else begin
            state <= state_nxt;
            if (flush_i) begin
                m_ctrl <= '0;
                s_ctrl <= '0;
            end else begin
                if (ld_m_in) begin
                    m_ctrl <= cap_ctrl;
                    m_data <= data_i;
                end
                if (ld_s_in) begin
                    s_ctrl <= cap_ctrl;
                    s_data <= data_i;
                end
                if (ld_m_s) begin
                    m_ctrl <= s_ctrl;
                    m_data <= s_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
    localparam int CW = 8;
    localparam int DW = 111;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [CW-1:0] ctrl_i = '0;
    logic [DW-1:0] data_i = '0;
    logic          kill_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic [CW-1:0] ctrl_o;
    logic [DW-1:0] data_o;
    logic          full_o;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .ctrl_i(ctrl_i), .data_i(data_i), .kill_i(kill_i), .flush_i(flush_i),
        .valid_o(valid_o), .ready_i(ready_i), .ctrl_o(ctrl_o), .data_o(data_o),
        .full_o(full_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a FIFO of at most two entries; the head is what the
    // stage presents downstream.
    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t mq[$];
    bit   mdl_ok = 0;
    bit   zflag  = 0;   // last thing that touched the head was reset/flush
    int   popped = 0;
    int   pushed = 0;
    int   dut_deliv = 0;

    always @(posedge clk) begin
        automatic bit acc = valid_i && (mq.size() < 2);
        automatic bit dq  = (mq.size() > 0) && ready_i;
        if (mdl_ok && !rst_i && valid_o && ready_i) dut_deliv++;
        if (rst_i) begin
            mq.delete();
            zflag  = 1;
            mdl_ok = 1;
        end else begin
            if (dq) begin
                void'(mq.pop_front());
                popped++;
            end
            if (flush_i) begin
                mq.delete();
                zflag = 1;
            end else if (acc) begin
                mq.push_back('{c: (kill_i ? '0 : ctrl_i), d: data_i});
                pushed++;
                zflag = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (mdl_ok) begin
            chk("valid_o", valid_o, mq.size() != 0);
            chk("ready_o", ready_o, mq.size() < 2);
            chk("full_o", full_o, mq.size() == 2);
            if (mq.size() != 0) begin
                chk("ctrl_o", ctrl_o, mq[0].c);
                chk("data_o", data_o, mq[0].d);
            end else if (zflag) begin
                chk("ctrl_o_cleared", ctrl_o, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d);
        valid_i = 1'b1;
        ctrl_i  = c;
        data_i  = d;
    endtask

    initial begin
        // T1 reset with garbage on the inputs
        #2;
        rst_i = 1'b1;
        send(8'hFF, 111'd9);
        step();
        chk("t1_valid", valid_o, 0);
        chk("t1_ctrl", ctrl_o, 0);
        chk("t1_data", data_o, 0);
        chk("t1_ready", ready_o, 1);
        chk("t1_full", full_o, 0);
        step();
        rst_i = 1'b0;
        valid_i = 1'b0;

        // T2 streaming
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(CW'(i + 1), DW'(100 + i));
            step();
            chk("t2_valid", valid_o, 1);
            chk("t2_ctrl", ctrl_o, i + 1);
            chk("t2_data", data_o, 100 + i);
            chk("t2_ready", ready_o, 1);
        end
        valid_i = 1'b0;
        step();
        chk("t2_drained", valid_o, 0);

        // T3 backpressure into the skid entry
        ready_i = 1'b0;
        send(8'd1, 111'd100);
        step();
        chk("t3_one_ctrl", ctrl_o, 1);
        send(8'd2, 111'd101);
        step();
        chk("t3_full", full_o, 1);
        chk("t3_ready", ready_o, 0);
        chk("t3_hold_ctrl", ctrl_o, 1);
        chk("t3_hold_data", data_o, 100);
        valid_i = 1'b0;
        step();
        chk("t3_hold2_data", data_o, 100);
        ready_i = 1'b1;
        step();
        chk("t3_second_ctrl", ctrl_o, 2);
        chk("t3_second_data", data_o, 101);
        chk("t3_not_full", full_o, 0);
        step();
        chk("t3_empty", valid_o, 0);

        // T4 kill
        send(8'hA5, 111'd55);
        kill_i = 1'b1;
        step();
        kill_i = 1'b0;
        valid_i = 1'b0;
        chk("t4_valid", valid_o, 1);
        chk("t4_ctrl", ctrl_o, 0);
        chk("t4_data", data_o, 55);
        step();

        // T5 flush in TWO with an offered entry
        ready_i = 1'b0;
        send(8'd3, 111'd200);
        step();
        send(8'd4, 111'd201);
        step();
        chk("t5_full", full_o, 1);
        send(8'd5, 111'd202);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk("t5_valid", valid_o, 0);
        chk("t5_ctrl", ctrl_o, 0);
        chk("t5_ready", ready_o, 1);
        ready_i = 1'b1;
        step();
        chk("t5_no_ghost", valid_o, 0);
        // flush in ONE also discards a same-cycle accepted entry
        send(8'd6, 111'd300);
        step();
        send(8'd7, 111'd301);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk("t5_one_flush", valid_o, 0);
        step();
        chk("t5_one_no_ghost", valid_o, 0);

        // T6 reset beats flush and kill in TWO
        ready_i = 1'b0;
        send(8'd8, 111'd400);
        step();
        send(8'd9, 111'd401);
        step();
        chk("t6_full", full_o, 1);
        rst_i = 1'b1;
        flush_i = 1'b1;
        kill_i = 1'b1;
        step();
        rst_i = 1'b0;
        flush_i = 1'b0;
        kill_i = 1'b0;
        valid_i = 1'b0;
        chk("t6_valid", valid_o, 0);
        chk("t6_ctrl", ctrl_o, 0);
        chk("t6_ready", ready_o, 1);
        chk("t6_full0", full_o, 0);

        // T6 random stream of 1000 accepted entries
        begin
            int acc_cnt = 0;
            int cyc = 0;
            int seq = 0;
            logic [127:0] r;
            while (acc_cnt < 1000 && cyc < 20000) begin
                valid_i = ($urandom_range(0, 3) != 0);
                ready_i = ($urandom_range(0, 2) != 0);
                kill_i  = ($urandom_range(0, 7) == 0);
                flush_i = ($urandom_range(0, 49) == 0);
                ctrl_i  = CW'($urandom);
                r = {$urandom, $urandom, $urandom, 32'(seq)};
                data_i = r[DW-1:0];
                if (valid_i && ready_o) begin
                    acc_cnt++;
                    seq++;
                end
                step();
                cyc++;
            end
            chk("t6_stream_done", acc_cnt, 1000);
            valid_i = 1'b0;
            kill_i  = 1'b0;
            flush_i = 1'b0;
            ready_i = 1'b1;
            repeat (4) step();
            chk("t6_drained", valid_o, 0);
            chk("t6_deliv_count", dut_deliv, popped);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
